// File: rtl/ram_pkg.sv
// Shared opcodes, FSM states and address-mode encodings for the quad-SPI SRAM model.
package ram_pkg;

  localparam logic [7:0] CMD_WRMR  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_RDMR  = 8'h05;

  localparam int DUMMY_CYCLES = 2;

  // Mode register bits[7:6]; 2'b11 is treated like SEQ.
  localparam logic [1:0] MODE_BYTE  = 2'b00;
  localparam logic [1:0] MODE_SEQ   = 2'b01;
  localparam logic [1:0] MODE_PAGE  = 2'b10;
  localparam logic [7:0] MODE_RESET = 8'h40;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_WMODE,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/ram_if.sv
// Host-side quad-SPI pins of the SRAM: chip select, serial clock and the 4-bit IO bus.
interface ram_if;
  logic       csn;
  logic       sclk;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic [3:0] io_oe;

  modport master (output csn, sclk, io_in, input io_out, io_oe);
  modport slave  (input csn, sclk, io_in, output io_out, io_oe);
endinterface

// File: rtl/ram_pin_sync.sv
// Two-flop synchronizers for the host pins plus csn-fall and sclk rise/fall pulses.
module ram_pin_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       csn,
  input  logic       sclk,
  input  logic [3:0] io_in,
  output logic       csn_s,
  output logic       csn_fall,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic [3:0] io_s
);
  logic [2:0] csn_q;
  logic [2:0] sclk_q;
  logic [3:0] io_q1;
  logic [3:0] io_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      csn_q  <= 3'b111;
      sclk_q <= 3'b000;
      io_q1  <= '0;
      io_q2  <= '0;
    end else begin
      csn_q  <= {csn_q[1:0], csn};
      sclk_q <= {sclk_q[1:0], sclk};
      io_q1  <= io_in;
      io_q2  <= io_q1;
    end
  end

  // io_s has the same latency as sclk_q[1], so it is the value present at the rise
  assign csn_s     = csn_q[1];
  assign csn_fall  = ~csn_q[1] & csn_q[2];
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign io_s      = io_q2;

endmodule

// File: rtl/ram.sv
// ram: quad-SPI SRAM device model serving a byte array over oversampled host pins.
// Define RAM_MODE_REG_EN to add the WRMR/RDMR mode register (BYTE/PAGE/SEQ addressing).
module ram
  import ram_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 65536
) (
  input logic  clk,
  input logic  rst,
  ram_if.slave bus
);
  // state  | meaning
  // IDLE   | csn high, waiting for csn fall
  // CMD    | shifting in the 2 command nibbles
  // ADDR   | shifting in ADDR_W/4 address nibbles, MSB first
  // DUMMY  | read turnaround, counts dummy SCLKs down to 0
  // RDATA  | driving data nibbles, advancing on SCLK fall
  // WDATA  | collecting nibble pairs into array writes
  // WMODE  | collecting the mode register byte
  // IGNORE | unknown command, pins stay released until csn rises

  localparam int NIBS = ADDR_W / 4;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t              state;
  logic                csn_s, csn_fall, sclk_rise, sclk_fall;
  logic [3:0]          io_s;
  logic [3:0]          cmd_hi;
  logic [7:0]          op;
  logic [ADDR_W-5:0]   addr_sh;
  logic [ADDR_W-1:0]   addr, addr_cmd, addr_nxt;
  logic [3:0]          cnt;
  logic [3:0]          wr_hi;
  logic                lo_phase, is_read, rd_mr;
  logic [3:0]          io_out_q, io_oe_q;
  logic [7:0]          mode_byte, rd_byte, nxt_byte;
  logic [7:0]          mem [DEPTH];

  ram_pin_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .csn       (bus.csn),
    .sclk      (bus.sclk),
    .io_in     (bus.io_in),
    .csn_s     (csn_s),
    .csn_fall  (csn_fall),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .io_s      (io_s)
  );

`ifdef RAM_MODE_REG_EN
  logic [7:0] mode_reg;
  assign mode_byte = mode_reg;
`else
  assign mode_byte = MODE_RESET;
`endif

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [1:0] m);
    case (m)
      MODE_BYTE: return a;
      MODE_PAGE: return {a[ADDR_W-1:5], a[4:0] + 5'd1};
      default:   return (a == LAST) ? '0 : a + ADDR_W'(1);
    endcase
  endfunction

  assign op       = {cmd_hi, io_s};
  assign addr_cmd = ADDR_W'(32'({addr_sh, io_s}) % DEPTH);
  assign addr_nxt = next_addr(addr, mode_byte[7:6]);
  assign rd_byte  = rd_mr ? mode_byte : mem[addr];
  assign nxt_byte = rd_mr ? mode_byte : mem[addr_nxt];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      io_out_q <= '0;
      io_oe_q  <= '0;
      addr     <= '0;
      addr_sh  <= '0;
      cmd_hi   <= '0;
      cnt      <= '0;
      wr_hi    <= '0;
      lo_phase <= 1'b0;
      is_read  <= 1'b0;
      rd_mr    <= 1'b0;
`ifdef RAM_MODE_REG_EN
      mode_reg <= MODE_RESET;
`endif
    end else if (csn_s) begin
      state    <= ST_IDLE;
      io_oe_q  <= '0;
      lo_phase <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (csn_fall) begin
          state <= ST_CMD;
          cnt   <= 4'd1;
        end
        ST_CMD: if (sclk_rise) begin
          cmd_hi <= io_s;
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            lo_phase <= 1'b0;
            rd_mr    <= 1'b0;
            case (op)
              CMD_READ: begin
                state   <= ST_ADDR;
                is_read <= 1'b1;
                cnt     <= 4'(NIBS - 1);
              end
              CMD_WRITE: begin
                state   <= ST_ADDR;
                is_read <= 1'b0;
                cnt     <= 4'(NIBS - 1);
              end
`ifdef RAM_MODE_REG_EN
              CMD_WRMR: state <= ST_WMODE;
              // RDMR skips address and dummy: the next SCLK fall starts driving
              CMD_RDMR: begin
                state <= ST_DUMMY;
                cnt   <= 4'd0;
                rd_mr <= 1'b1;
              end
`endif
              default: state <= ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: if (sclk_rise) begin
          addr_sh <= {addr_sh[ADDR_W-9:0], io_s};
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            addr     <= addr_cmd;
            lo_phase <= 1'b0;
            state    <= is_read ? ST_DUMMY : ST_WDATA;
            cnt      <= 4'(DUMMY_CYCLES);
          end
        end
        ST_DUMMY: begin
          if (sclk_rise && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (sclk_fall && cnt == 4'd0) begin
            state    <= ST_RDATA;
            io_oe_q  <= 4'hF;
            io_out_q <= rd_byte[7:4];
            lo_phase <= 1'b0;
          end
        end
        ST_RDATA: if (sclk_fall) begin
          if (!lo_phase) begin
            io_out_q <= rd_byte[3:0];
            lo_phase <= 1'b1;
          end else begin
            io_out_q <= nxt_byte[7:4];
            lo_phase <= 1'b0;
            if (!rd_mr) addr <= addr_nxt;
          end
        end
        ST_WDATA: if (sclk_rise) begin
          if (!lo_phase) begin
            wr_hi    <= io_s;
            lo_phase <= 1'b1;
          end else begin
            lo_phase <= 1'b0;
            addr     <= addr_nxt;
          end
        end
`ifdef RAM_MODE_REG_EN
        ST_WMODE: if (sclk_rise) begin
          if (!lo_phase) begin
            wr_hi    <= io_s;
            lo_phase <= 1'b1;
          end else begin
            mode_reg <= {wr_hi, io_s};
            lo_phase <= 1'b0;
          end
        end
`endif
        ST_IGNORE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array is not reset; a byte lands only when its low nibble arrives.
  always_ff @(posedge clk) begin
    if (!rst && !csn_s && state == ST_WDATA && sclk_rise && lo_phase)
      mem[addr] <= {wr_hi, io_s};
  end

  assign bus.io_out = io_out_q;
  assign bus.io_oe  = io_oe_q;

endmodule

// File: tb/tb_ram.sv
// Directed bench for the quad-SPI SRAM model: table of host transactions plus
// hand-written abort/reset sequences. Mode-register vectors follow RAM_MODE_REG_EN.
module tb_ram;
  import ram_pkg::*;

  localparam int H = 8;

  logic clk = 1'b0;
  logic rst;
  ram_if bus();

  ram #(.ADDR_W(16), .DEPTH(65536)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum int {K_WR, K_RD, K_IGN, K_ABORT, K_WRMR, K_RDMR} kind_t;
  typedef struct {
    kind_t       kind;
    logic [7:0]  op;
    logic [15:0] addr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int          nb;
    int          nr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] nib, output logic [3:0] rd, output logic [3:0] oe);
    bus.io_in = nib;
    repeat (H) @(negedge clk);
    rd = bus.io_out;
    oe = bus.io_oe;
    bus.sclk = 1'b1;
    repeat (H) @(negedge clk);
    bus.sclk = 1'b0;
  endtask

  task automatic start_t();
    bus.csn = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic stop_t();
    bus.csn  = 1'b1;
    bus.sclk = 1'b0;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic send_nib(input logic [3:0] n, inout int bad);
    logic [3:0] r, o;
    cyc(n, r, o);
    if (o != 4'h0) bad++;
  endtask

  task automatic send_byte(input logic [7:0] b, inout int bad);
    send_nib(b[7:4], bad);
    send_nib(b[3:0], bad);
  endtask

  task automatic send_addr(input logic [15:0] a, inout int bad);
    send_byte(a[15:8], bad);
    send_byte(a[7:0], bad);
  endtask

  task automatic read_nibs(input int n, output logic [15:0] got, inout int bad_rd);
    logic [3:0] r, o;
    got = '0;
    for (int i = 0; i < n; i++) begin
      cyc(4'h0, r, o);
      got = {got[11:0], r};
      if (o != 4'hF) bad_rd++;
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int          bad;
    int          bad_rd;
    logic [15:0] got;
    bad    = 0;
    bad_rd = 0;
    got    = '0;
    start_t();
    send_byte(v.op, bad);
    case (v.kind)
      K_WR: begin
        send_addr(v.addr, bad);
        if (v.nb > 0) send_byte(v.d0, bad);
        if (v.nb > 1) send_byte(v.d1, bad);
      end
      K_ABORT: begin
        send_addr(v.addr, bad);
        send_nib(v.d0[7:4], bad);
      end
      K_WRMR: send_byte(v.d0, bad);
      K_RD: begin
        send_addr(v.addr, bad);
        send_nib(4'h0, bad);
        send_nib(4'h0, bad);
        read_nibs(v.nr, got, bad_rd);
      end
      K_RDMR: read_nibs(v.nr, got, bad_rd);
      K_IGN: for (int i = 0; i < 8; i++) send_nib(4'(i * 5 + 3), bad);
      default: ;
    endcase
    stop_t();
    chk($sformatf("v%0d_oe_released", id), bad, 0);
    if (v.kind == K_RD || v.kind == K_RDMR) begin
      chk($sformatf("v%0d_data", id), {16'h0, got}, {16'h0, v.exp});
      chk($sformatf("v%0d_oe_driven", id), bad_rd, 0);
      chk($sformatf("v%0d_oe_after_csn", id), {28'h0, bus.io_oe}, 32'h0);
    end
  endtask

  function automatic vec_t mk(kind_t k, logic [7:0] op, logic [15:0] a, logic [7:0] d0,
                              logic [7:0] d1, int nb, int nr, logic [15:0] e);
    vec_t v;
    v.kind = k; v.op = op; v.addr = a; v.d0 = d0; v.d1 = d1;
    v.nb = nb; v.nr = nr; v.exp = e;
    return v;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         bad;
    logic [3:0] r, o;
    bad      = 0;
    rst      = 1'b1;
    bus.csn  = 1'b1;
    bus.sclk = 1'b0;
    bus.io_in = 4'h0;
    repeat (2) @(negedge clk);
    chk("reset_oe", {28'h0, bus.io_oe}, 32'h0);
    chk("reset_out", {28'h0, bus.io_out}, 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_oe", {28'h0, bus.io_oe}, 32'h0);
    chk("idle_out", {28'h0, bus.io_out}, 32'h0);

    vecs.push_back(mk(K_WR,    CMD_WRITE, 16'h1234, 8'hA5, 8'h3C, 2, 0, 16'h0000));
    vecs.push_back(mk(K_RD,    CMD_READ,  16'h1234, 8'h00, 8'h00, 0, 4, 16'hA53C));
    vecs.push_back(mk(K_WR,    CMD_WRITE, 16'hFFFF, 8'h11, 8'h22, 2, 0, 16'h0000));
    vecs.push_back(mk(K_RD,    CMD_READ,  16'h0000, 8'h00, 8'h00, 0, 2, 16'h0022));
    vecs.push_back(mk(K_RD,    CMD_READ,  16'hFFFF, 8'h00, 8'h00, 0, 4, 16'h1122));
    vecs.push_back(mk(K_WR,    CMD_WRITE, 16'h0040, 8'h55, 8'h00, 1, 0, 16'h0000));
    vecs.push_back(mk(K_ABORT, CMD_WRITE, 16'h0040, 8'h70, 8'h00, 0, 0, 16'h0000));
    vecs.push_back(mk(K_RD,    CMD_READ,  16'h0040, 8'h00, 8'h00, 0, 2, 16'h0055));
    vecs.push_back(mk(K_IGN,   8'h9F,     16'h0000, 8'h00, 8'h00, 0, 0, 16'h0000));
    vecs.push_back(mk(K_RD,    CMD_READ,  16'h1235, 8'h00, 8'h00, 0, 2, 16'h003C));
    vecs.push_back(mk(K_WR,    CMD_WRITE, 16'h0100, 8'hDE, 8'hAD, 2, 0, 16'h0000));
    vecs.push_back(mk(K_RD,    CMD_READ,  16'h0101, 8'h00, 8'h00, 0, 2, 16'h00AD));
    vecs.push_back(mk(K_RD,    CMD_READ,  16'h0100, 8'h00, 8'h00, 0, 4, 16'hDEAD));
`ifdef RAM_MODE_REG_EN
    vecs.push_back(mk(K_RDMR,  CMD_RDMR,  16'h0000, 8'h00, 8'h00, 0, 2, 16'h0040));
    vecs.push_back(mk(K_WRMR,  CMD_WRMR,  16'h0000, 8'h00, 8'h00, 1, 0, 16'h0000));
    vecs.push_back(mk(K_WR,    CMD_WRITE, 16'h0010, 8'h01, 8'h02, 2, 0, 16'h0000));
    vecs.push_back(mk(K_RD,    CMD_READ,  16'h0010, 8'h00, 8'h00, 0, 4, 16'h0202));
    vecs.push_back(mk(K_RDMR,  CMD_RDMR,  16'h0000, 8'h00, 8'h00, 0, 2, 16'h0000));
    vecs.push_back(mk(K_WRMR,  CMD_WRMR,  16'h0000, 8'h80, 8'h00, 1, 0, 16'h0000));
    vecs.push_back(mk(K_WR,    CMD_WRITE, 16'h001F, 8'hAA, 8'hBB, 2, 0, 16'h0000));
    vecs.push_back(mk(K_RD,    CMD_READ,  16'h0000, 8'h00, 8'h00, 0, 2, 16'h00BB));
    vecs.push_back(mk(K_RD,    CMD_READ,  16'h001F, 8'h00, 8'h00, 0, 4, 16'hAABB));
    vecs.push_back(mk(K_RDMR,  CMD_RDMR,  16'h0000, 8'h00, 8'h00, 0, 4, 16'h8080));
    vecs.push_back(mk(K_WRMR,  CMD_WRMR,  16'h0000, 8'h40, 8'h00, 1, 0, 16'h0000));
`else
    vecs.push_back(mk(K_IGN,   CMD_RDMR,  16'h0000, 8'h00, 8'h00, 0, 0, 16'h0000));
    vecs.push_back(mk(K_IGN,   CMD_WRMR,  16'h0000, 8'h00, 8'h00, 0, 0, 16'h0000));
`endif
    vecs.push_back(mk(K_RD,    CMD_READ,  16'h1234, 8'h00, 8'h00, 0, 4, 16'hA53C));

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // csn rising mid-read must release the pins within 3 clk
    start_t();
    send_byte(CMD_READ, bad);
    send_addr(16'h1234, bad);
    send_nib(4'h0, bad);
    send_nib(4'h0, bad);
    cyc(4'h0, r, o);
    chk("drop_first_nib", {28'h0, r}, 32'hA);
    chk("drop_oe_before", {28'h0, o}, 32'hF);
    bus.csn = 1'b1;
    repeat (3) @(negedge clk);
    chk("drop_oe_3clk", {28'h0, bus.io_oe}, 32'h0);
    repeat (2 * H) @(negedge clk);

    // rst during a read clears outputs on the next clk
    start_t();
    send_byte(CMD_READ, bad);
    send_addr(16'h1234, bad);
    send_nib(4'h0, bad);
    send_nib(4'h0, bad);
    cyc(4'h0, r, o);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_read_oe", {28'h0, bus.io_oe}, 32'h0);
    chk("rst_mid_read_out", {28'h0, bus.io_out}, 32'h0);
    bus.csn = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * H) @(negedge clk);

    // rst on the rise that would complete a byte must not write it
    start_t();
    send_byte(CMD_WRITE, bad);
    send_addr(16'h0040, bad);
    send_nib(4'h9, bad);
    bus.io_in = 4'h1;
    rst       = 1'b1;
    bus.sclk  = 1'b1;
    repeat (4) @(negedge clk);
    bus.sclk = 1'b0;
    bus.csn  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2 * H) @(negedge clk);
    chk("hand_oe_released", bad, 0);
    run_vec(100, mk(K_RD, CMD_READ, 16'h0040, 8'h00, 8'h00, 0, 2, 16'h0055));
    run_vec(101, mk(K_RD, CMD_READ, 16'hFFFF, 8'h00, 8'h00, 0, 2, 16'h0011));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
